// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB requester
// Purpose: FSM state encoding, strobe width and APB response codes
//          used by apb_master_fsm and apb_timeout_ctr.
// Ports:   none (package)
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/apb_timeout_ctr.sv
// rtl/apb_timeout_ctr.sv - ACCESS-phase wait-state counter with expiry flag
// Purpose: counts ACCESS cycles without PREADY; expire_o rises when the
//          count reaches TIMEOUT_CYCLES-1.
// Ports:   clk_i     clock
//          rst_i     asynchronous active-high reset
//          clear_i   zero the count (asserted the cycle before ACCESS)
//          en_i      count one more stalled ACCESS cycle
//          expire_o  count has reached TIMEOUT_CYCLES-1
module apb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expire_o = (count_q == LAST);

  // Saturate at LAST so a held enable can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !expire_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_master_fsm.sv
// rtl/apb_master_fsm.sv - APB4 requester driven by the AXI4-lite front end
// Purpose: turns a one-cycle transfer request into one APB SETUP/ACCESS
//          transaction and returns read data, an error flag and a
//          one-cycle completion pulse. Optional ACCESS timeout when
//          APB_TIMEOUT_EN is defined.
// Ports:   PCLK, PRESET                         clock, async active-high reset
//          transfer, read, write                request pulse and direction
//          apb_waddr, apb_raddr, apb_wdata,
//          apb_strb                             latched request payload
//          apb_rdata, err_flag, apb_done        response to the front end
//          PSEL, PENABLE, PWRITE, PADDR,
//          PWDATA, PSTRB                        APB requester outputs
//          PRDATA, PREADY, PSLVERR              APB completer inputs
module apb_master_fsm
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  transfer,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] apb_waddr,
  input  logic [ADDR_WIDTH-1:0] apb_raddr,
  input  logic [DATA_WIDTH-1:0] apb_wdata,
  input  logic [STRB_W-1:0]     apb_strb,
  output logic [DATA_WIDTH-1:0] apb_rdata,
  output logic                  err_flag,
  output logic                  apb_done,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_W-1:0]     PSTRB,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e            state_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  done_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_W-1:0]     pstrb_q;
  logic                  timeout_hit;

`ifdef APB_TIMEOUT_EN
  apb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .clear_i  (state_q == SETUP),
    .en_i     ((state_q == ACCESS) && !PREADY),
    .expire_o (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A transfer with neither direction bit is dropped; write wins a tie.
          if (transfer && (write || read)) begin
            psel_q   <= 1'b1;
            pwrite_q <= write;
            paddr_q  <= write ? apb_waddr : apb_raddr;
            pwdata_q <= write ? apb_wdata : '0;
            pstrb_q  <= write ? apb_strb  : '0;
            err_q    <= 1'b0;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // PREADY in the terminal cycle beats the timeout.
          if (PREADY) begin
            if (!pwrite_q) begin
              rdata_q <= PRDATA;
            end
            err_q     <= PSLVERR;
            done_q    <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= IDLE;
          end else if (timeout_hit) begin
            err_q     <= 1'b1;
            done_q    <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign apb_rdata = rdata_q;
  assign err_flag  = err_q;
  assign apb_done  = done_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;

endmodule

// File: doc/apb_master_fsm.md
Name: apb_master_fsm

Overview:
- APB4 requester stage directly downstream of the AXI4-lite slave front end.
- Consumes the front end's one-cycle transfer/read/write request with its latched address, data and strobe, and runs one APB SETUP/ACCESS transaction.
- Returns read data, an error flag and a one-cycle completion pulse for the front end's AXI response.
- Single outstanding transfer; one APB completer port.

Parameters:
- ADDR_WIDTH, 32, width of PADDR, apb_waddr, apb_raddr.
- DATA_WIDTH, 32, width of PWDATA, PRDATA, apb_wdata, apb_rdata.
- TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit (used only with APB_TIMEOUT_EN).

Ports:
- PCLK  in  1  clock, shared with the AXI front end
- PRESET  in  1  asynchronous, active-high reset
- transfer  in  1  one-cycle request pulse
- read  in  1  qualifies transfer as a read
- write  in  1  qualifies transfer as a write
- apb_waddr  in  ADDR_WIDTH  write address, stable from the transfer cycle
- apb_raddr  in  ADDR_WIDTH  read address, stable from the transfer cycle
- apb_wdata  in  DATA_WIDTH  write data
- apb_strb  in  4  write byte strobes
- apb_rdata  out  DATA_WIDTH  captured PRDATA, held until the next request
- err_flag  out  1  captured PSLVERR (or timeout), held until the next request
- apb_done  out  1  one-cycle completion pulse
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PSTRB  out  4  APB strobes
- PRDATA  in  DATA_WIDTH  completer read data
- PREADY  in  1  completer ready
- PSLVERR  in  1  completer error

Behaviour:
- Reset (async assert, sync release to first PCLK edge): all outputs 0; state IDLE. Reset mid-transfer drops PSEL/PENABLE immediately; no apb_done is produced.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - On transfer=1 with write=1: register PADDR=apb_waddr, PWDATA=apb_wdata, PSTRB=apb_strb, PWRITE=1; clear err_flag; go to SETUP.
  - On transfer=1 with read=1 (write=0): PADDR=apb_raddr, PWDATA=0, PSTRB=0, PWRITE=0; clear err_flag; go to SETUP.
  - read and write both set: write wins.
  - transfer with neither read nor write: ignored, stays IDLE.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR, PWRITE, PWDATA and PSTRB held stable.
  - Wait states are unlimited while PREADY=0.
  - On the edge with PREADY=1: capture PRDATA into apb_rdata (reads only; writes leave apb_rdata unchanged), capture err_flag=PSLVERR, pulse apb_done=1 for the following cycle, drop PSEL/PENABLE, go to IDLE.
- Latency: transfer sampled at edge e0 → SETUP after e0 → ACCESS after e1 → with zero wait states, apb_done is high after e2. Each wait state adds one cycle. The front end is already in its WAIT state by then.
- Back-to-back: IDLE accepts a new transfer in the same cycle apb_done is high. No SETUP-to-SETUP shortcut.
- transfer arriving while not IDLE is ignored; the front end guarantees it never sends one.
- apb_done is never high for two consecutive cycles.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A counter, cleared on entering ACCESS, increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES-1 without PREADY, the transfer aborts: err_flag=1, apb_rdata unchanged, apb_done pulses, PSEL/PENABLE drop, go to IDLE.
  - PREADY=1 in the terminal cycle takes precedence over the timeout.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Shared package apb_pkg: state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2), PSTRB width constant 4, response constants OKAY=2'b00 and SLVERR=2'b10.
- One natural sub-module, apb_timeout_ctr (clear/enable/expire), instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Write, zero wait: transfer+write, apb_waddr=0x1000, apb_wdata=0xDEADBEEF, apb_strb=4'hF, PREADY tied 1 → PSEL 2 cycles, PENABLE 1 cycle, PWRITE=1, apb_done after e2, err_flag=0.
- Read, 3 wait states: apb_raddr=0x2004, PRDATA=0x12345678 on the PREADY cycle → PSTRB=0, apb_done 5 cycles after transfer, apb_rdata=0x12345678 held afterwards.
- Error: read with PSLVERR=1 and PREADY=1 → err_flag=1 held; next request clears it to 0 at the IDLE edge.
- Back-to-back: a second transfer in the apb_done cycle → new SETUP starts the next cycle; PADDR changes only at SETUP.
- Reset during ACCESS (PREADY=0) → PSEL/PENABLE/apb_done 0 immediately; IDLE after release.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY held 0 → abort after 8 ACCESS cycles with err_flag=1 and one apb_done pulse.
